// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding and helpers for the APB request arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam int MAX_NREQ = 8;

    function automatic int onehot2idx(input logic [MAX_NREQ-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - combinational round-robin picker, search starts just after ptr
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW-1:0]       cand;
    logic [MAX_NREQ-1:0] oh_ext;

    always_comb begin
        gnt_oh = '0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (gnt_oh == '0 && req[cand]) gnt_oh[cand] = 1'b1;
        end
    end

    assign any    = |req;
    assign oh_ext = MAX_NREQ'(gnt_oh);
    assign idx    = PW'(onehot2idx(oh_ext));

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin sharing of one APB master between NREQ requesters
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 8
) (
    input  logic             clk_APB,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_w,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic [DW-1:0]    rdata,
    output logic             busy,
    output logic             MISEL,
    output logic             MIW,
    output logic [AW-1:0]    MIADDR,
    output logic [DW-1:0]    MIDATA,
    input  logic             PSEL,
    input  logic             PEN,
    input  logic             PREADY,
    input  logic [DW-1:0]    MODATA
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any;
    logic            grant_now;
    logic            xfer_end;

    apb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign grant_now = (state == ST_IDLE) && pick_any;
    assign xfer_end  = (state == ST_WAIT) && PSEL && PEN && PREADY;

    always_ff @(posedge clk_APB or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_any)     state_nxt = ST_REQ;
            ST_REQ:  if (PSEL && !PEN) state_nxt = ST_WAIT;
            ST_WAIT: if (xfer_end)     state_nxt = ST_DONE;
            ST_DONE:                   state_nxt = ST_IDLE;
        endcase
    end

    // Fields are frozen at grant so requesters may change them freely afterwards
    always_ff @(posedge clk_APB or negedge rst) begin
        if (!rst) begin
            gnt    <= '0;
            ptr    <= PW'(NREQ - 1);
            MIW    <= 1'b0;
            MIADDR <= '0;
            MIDATA <= '0;
            rdata  <= '0;
        end else begin
            if (grant_now) begin
                gnt    <= pick_oh;
                ptr    <= pick_idx;
                MIW    <= req_w[pick_idx];
                MIADDR <= req_addr[int'(pick_idx)*AW +: AW];
                MIDATA <= req_wdata[int'(pick_idx)*DW +: DW];
            end else if (state == ST_DONE) begin
                gnt <= '0;
            end
            if (xfer_end && !MIW) rdata <= MODATA;
        end
    end

    assign MISEL = (state == ST_REQ);
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE) ? gnt : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter with APB master/slave model
module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 8;

    logic clk_APB = 1'b0;
    logic rst     = 1'b0;
    logic [NREQ-1:0]    req = '0, req_w = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    gnt, done;
    logic [DW-1:0]      rdata, MIDATA, MODATA;
    logic               busy, MISEL, MIW;
    logic [AW-1:0]      MIADDR;
    logic               PSEL, PEN;
    logic               PREADY = 1'b1;

    always #5 clk_APB = ~clk_APB;

    apb_req_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk_APB (clk_APB), .rst (rst),
        .req (req), .req_w (req_w), .req_addr (req_addr), .req_wdata (req_wdata),
        .gnt (gnt), .done (done), .rdata (rdata), .busy (busy),
        .MISEL (MISEL), .MIW (MIW), .MIADDR (MIADDR), .MIDATA (MIDATA),
        .PSEL (PSEL), .PEN (PEN), .PREADY (PREADY), .MODATA (MODATA)
    );

    // APB master + slave memory
    typedef enum int {M_IDLE, M_SETUP, M_ACCESS} m_st_t;
    m_st_t         m_st;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] mem [256];
    bit            mem_init = 1'b0;

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 32'h3C) return 32'hDEADBEEF;
        return (32'(a) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk_APB or negedge rst) begin
        if (!rst) begin
            m_st   <= M_IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            if (!mem_init) begin
                for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
                mem_init <= 1'b1;
            end
        end else begin
            case (m_st)
                M_IDLE: if (MISEL) begin
                    m_st <= M_SETUP; paddr <= MIADDR; pwrite <= MIW; pwdata <= MIDATA;
                end
                M_SETUP: m_st <= M_ACCESS;
                M_ACCESS: if (PREADY) begin
                    if (pwrite) mem[paddr] <= pwdata;
                    m_st <= MISEL ? M_SETUP : M_IDLE;
                end
            endcase
        end
    end

    assign PSEL   = (m_st != M_IDLE);
    assign PEN    = (m_st == M_ACCESS);
    assign MODATA = mem[paddr];

    // Reference model and scoreboard
    typedef struct {
        int            idx;
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0, errors = 0;
    int            m_ptr;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] ref_rdata;
    logic          f_w     [NREQ];
    logic [AW-1:0] f_addr  [NREQ];
    logic [DW-1:0] f_wdata [NREQ];

    int pr_mode = 0;
    int acc_cnt = 0;
    bit scramble_en = 1'b1;
    bit ivl_en = 1'b0;
    bit stab_bad = 1'b0;
    int cyc = 0;
    int last_done = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_issue(input logic [NREQ-1:0] set);
        logic [NREQ-1:0] pend;
        exp_t e;
        int pick;
        pend = set;
        while (pend != 0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++)
                if (pick < 0 && pend[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
            e.idx = pick; e.w = f_w[pick]; e.addr = f_addr[pick]; e.wdata = f_wdata[pick];
            if (e.w) begin
                e.rdata = ref_rdata;
                ref_mem[e.addr] = e.wdata;
            end else begin
                ref_rdata = ref_mem[e.addr];
                e.rdata = ref_rdata;
            end
            exp_q.push_back(e);
            m_ptr = pick;
            pend[pick] = 1'b0;
        end
    endtask

    always @(posedge clk_APB) cyc++;

    always @(negedge clk_APB) begin
        if (!rst) stab_bad = 1'b0;
        if (rst && busy && exp_q.size() > 0) begin
            if (MIADDR !== exp_q[0].addr || MIW !== exp_q[0].w || MIDATA !== exp_q[0].wdata)
                stab_bad = 1'b1;
        end
        if (rst && done != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_winner", done, 64'(1) << mon_e.idx);
                check("gnt_held", gnt, done);
                check("gnt_onehot0", $onehot0(gnt), 1);
                check("paddr", paddr, mon_e.addr);
                check("pwrite", pwrite, mon_e.w);
                if (mon_e.w) check("pwdata", pwdata, mon_e.wdata);
                check("rdata", rdata, mon_e.rdata);
                check("fields_stable", stab_bad, 0);
            end
            stab_bad = 1'b0;
            if (ivl_en) begin
                if (last_done >= 0) check("repeat_interval", cyc - last_done, 5);
                last_done = cyc;
            end
        end
        if (!ivl_en) last_done = -1;
    end

    // Stimulus: all requester driving happens here
    task automatic tick();
        @(negedge clk_APB);
        for (int i = 0; i < NREQ; i++) begin
            if (done[i]) req[i] = 1'b0;
            if (gnt[i] && scramble_en && $urandom_range(0, 1) == 1) begin
                req_addr[i*AW +: AW]  = AW'($urandom);
                req_wdata[i*DW +: DW] = $urandom;
                req_w[i] = ~req_w[i];
            end
        end
        if (PSEL && PEN) acc_cnt++; else acc_cnt = 0;
        case (pr_mode)
            0:       PREADY = 1'b1;
            1:       PREADY = ($urandom_range(0, 2) != 0);
            2:       PREADY = 1'b0;
            default: PREADY = (acc_cnt >= 4);
        endcase
    endtask

    task automatic start(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        f_w[i] = w; f_addr[i] = a; f_wdata[i] = d;
        req_w[i] = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        int lat, n, m;
        logic [NREQ-1:0] set;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        m_ptr = NREQ - 1;
        ref_rdata = '0;

        repeat (3) @(negedge clk_APB);
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_misel", MISEL, 0);
        check("rst_rdata", rdata, 0);
        check("rst_miaddr", {MIW, MIADDR, MIDATA}, 0);
        rst = 1'b1;
        tick();

        // single read with latency measurement
        pr_mode = 0;
        start(2, 1'b0, 8'h3C, 32'h0BAD_F00D);
        model_issue(4'b0100);
        tick();
        lat = 1;
        check("read_gnt_c1", gnt, 4'b0100);
        while (done == '0 && lat < 20) begin
            tick();
            lat++;
        end
        check("read_latency", lat, 4);
        drain();
        check("read_rdata", rdata, 32'hDEADBEEF);

        // write with three wait states
        pr_mode = 3;
        start(0, 1'b1, 8'h10, 32'h12345678);
        model_issue(4'b0001);
        drain();
        check("write_keeps_rdata", rdata, 32'hDEADBEEF);

        // all four requesting, PREADY always high
        pr_mode = 0;
        ivl_en = 1'b1;
        for (int i = 0; i < NREQ; i++) start(i, 1'(i & 1), AW'(8'h40 + i), $urandom);
        model_issue(4'b1111);
        drain();
        ivl_en = 1'b0;

        // field change after grant
        start(0, 1'b0, 8'h20, 32'h1111_2222);
        model_issue(4'b0001);
        tick();
        req_addr[0 +: AW] = 8'h44;
        drain();

        // late requester arriving during WAIT
        pr_mode = 3;
        start(1, 1'b0, 8'h10, 32'h0);
        model_issue(4'b0010);
        n = 0;
        while (!(PSEL && PEN) && n < 50) begin
            tick();
            n++;
        end
        start(3, 1'b1, 8'h3C, 32'hCAFE_0003);
        model_issue(4'b1000);
        drain();

        // reset in the middle of WAIT
        pr_mode = 2;
        start(1, 1'b0, 8'h05, 32'h0);
        model_issue(4'b0010);
        n = 0;
        while (!(PSEL && PEN) && n < 50) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b0;
        req = '0;
        exp_q.delete();
        m_ptr = NREQ - 1;
        ref_rdata = '0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_gnt", gnt, 0);
        check("midrst_done", done, 0);
        check("midrst_misel", MISEL, 0);
        check("midrst_rdata", rdata, 0);
        tick();
        rst = 1'b1;
        pr_mode = 0;
        start(1, 1'b0, 8'h07, 32'h0);
        start(3, 1'b0, 8'h08, 32'h0);
        model_issue(4'b1010);
        tick();
        check("post_rst_gnt", gnt, 4'b0010);
        drain();

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            m = $urandom_range(0, 2);
            pr_mode = (m == 2) ? 3 : m;
            set = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++)
                if (set[i]) start(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            model_issue(set);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
